// File: rtl/fmsynth_envgen.sv
// Time-multiplexed ADSR envelope generator: one operator issued per clock after sample_tick.
// Result for op k appears 2 cycles after its read; no backpressure, overlapping ticks are dropped.
module fmsynth_envgen #(
  parameter int NUM_OPS = 36,
  parameter int ATT_W   = 9,
  localparam int OPW    = $clog2(NUM_OPS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic             cfg_wren,
  input  logic [OPW-1:0]   cfg_op,
  input  logic [15:0]      cfg_data,
  input  logic             key_wren,
  input  logic [OPW-1:0]   key_op,
  input  logic             key_on,
  output logic             att_valid,
  output logic [OPW-1:0]   att_op,
  output logic [ATT_W-1:0] att_out,
  output logic             busy,
  output logic             tick_drop
);

  localparam logic [ATT_W:0]   MAXATT  = {1'b0, {ATT_W{1'b1}}};
  localparam logic [OPW-1:0]   LAST_OP = OPW'(NUM_OPS - 1);
  localparam logic [OPW:0]     OPS_LIM = (OPW + 1)'(NUM_OPS);

  typedef enum logic [2:0] {ST_OFF, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE} env_st_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} sweep_st_t;

  sweep_st_t          state, state_nxt;
  logic [OPW-1:0]     issue_op;
  logic               issue;
  logic               drain_cnt;
  logic [15:0]        env_cnt;

  logic [15:0]        cfg_mem [NUM_OPS];
  env_st_t            st_mem  [NUM_OPS];
  logic [ATT_W-1:0]   att_mem [NUM_OPS];
  logic [NUM_OPS-1:0] pend_vld, pend_key;

  logic               s1_vld, s1_pend, s1_key;
  logic [OPW-1:0]     s1_op;
  logic [15:0]        s1_cfg;
  env_st_t            s1_st;
  logic [ATT_W-1:0]   s1_att;

  env_st_t            key_st, st_upd;
  logic [ATT_W:0]     att_upd, att_dec, sl_tgt;

  // Rate R steps when the low (15-R) bits of env_cnt are zero; R=15 gives an empty mask.
  function automatic logic rate_step(input logic [3:0] r, input logic [15:0] cnt);
    logic [15:0] mask;
    mask = 16'hFFFF >> ({1'b0, r} + 5'd1);
    return (r != 4'd0) && ((cnt & mask) == 16'd0);
  endfunction

  function automatic logic [ATT_W:0] rate_inc(input logic [3:0] r);
    return (r == 4'hF) ? (ATT_W + 1)'(8) : (ATT_W + 1)'(1);
  endfunction

  assign issue = (state == SWEEP);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = SWEEP;
      SWEEP:   if (issue_op == LAST_OP) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_op  <= '0;
      drain_cnt <= 1'b0;
      env_cnt   <= '0;
      tick_drop <= 1'b0;
    end else begin
      issue_op  <= (issue && issue_op != LAST_OP) ? issue_op + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == DRAIN && drain_cnt) env_cnt <= env_cnt + 16'd1;
      tick_drop <= sample_tick && busy;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OPS; i++) cfg_mem[i] <= '0;
    end else if (cfg_wren && {1'b0, cfg_op} < OPS_LIM) begin
      cfg_mem[cfg_op] <= cfg_data;
    end
  end

  // Pending is consumed at the read; a key write in that same cycle wins and waits a sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld <= '0;
      pend_key <= '0;
    end else begin
      if (issue) pend_vld[issue_op] <= 1'b0;
      if (key_wren && {1'b0, key_op} < OPS_LIM) begin
        pend_vld[key_op] <= 1'b1;
        pend_key[key_op] <= key_on;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_op   <= '0;
      s1_cfg  <= '0;
      s1_st   <= ST_OFF;
      s1_att  <= '0;
      s1_pend <= 1'b0;
      s1_key  <= 1'b0;
    end else begin
      s1_vld  <= issue;
      s1_op   <= issue_op;
      s1_cfg  <= cfg_mem[issue_op];
      s1_st   <= st_mem[issue_op];
      s1_att  <= att_mem[issue_op];
      s1_pend <= pend_vld[issue_op];
      s1_key  <= pend_key[issue_op];
    end
  end

  always_comb begin
    key_st = s1_st;
    if (s1_pend) begin
      if (s1_key)                key_st = ST_ATTACK;
      else if (s1_st != ST_OFF)  key_st = ST_RELEASE;
    end
    st_upd  = key_st;
    att_upd = {1'b0, s1_att};
    att_dec = ({1'b0, s1_att} >> 3) + (ATT_W + 1)'(1);
    sl_tgt  = (s1_cfg[7:4] == 4'hF) ? MAXATT
                                    : ({{(ATT_W - 3){1'b0}}, s1_cfg[7:4]} << (ATT_W - 5));
    case (key_st)
      ST_ATTACK: begin
        if (s1_cfg[15:12] == 4'hF)
          att_upd = '0;
        else if (rate_step(s1_cfg[15:12], env_cnt))
          att_upd = (att_upd > att_dec) ? att_upd - att_dec : '0;
        if (att_upd == '0) st_upd = ST_DECAY;
      end
      ST_DECAY: begin
        if (rate_step(s1_cfg[11:8], env_cnt)) att_upd = att_upd + rate_inc(s1_cfg[11:8]);
        if (att_upd > MAXATT) att_upd = MAXATT;
        if (att_upd >= sl_tgt) st_upd = ST_SUSTAIN;
      end
      ST_RELEASE: begin
        if (rate_step(s1_cfg[3:0], env_cnt)) att_upd = att_upd + rate_inc(s1_cfg[3:0]);
        if (att_upd >= MAXATT) begin
          att_upd = MAXATT;
          st_upd  = ST_OFF;
        end
      end
      ST_OFF:  att_upd = MAXATT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        st_mem[i]  <= ST_OFF;
        att_mem[i] <= MAXATT[ATT_W-1:0];
      end
      att_valid <= 1'b0;
      att_op    <= '0;
      att_out   <= '0;
    end else begin
      att_valid <= s1_vld;
      if (s1_vld) begin
        st_mem[s1_op]  <= st_upd;
        att_mem[s1_op] <= att_upd[ATT_W-1:0];
        att_op         <= s1_op;
        att_out        <= att_upd[ATT_W-1:0];
      end
    end
  end

endmodule
